// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg: shared state encoding and widths for the issue controller
package issue_ctrl_pkg;
  localparam int REG_AW = 5;
  localparam int CTRL_STATE_W = 2;
  typedef enum logic [CTRL_STATE_W-1:0] {
    CTRL_RUN     = 2'd0,
    CTRL_BR_WAIT = 2'd1,
    CTRL_FLUSH   = 2'd2,
    CTRL_HALT    = 2'd3
  } ctrl_state_e;
endpackage

// File: rtl/issue_ctrl_if.sv
// issue_ctrl_if: decode/EX/MEM/WB inputs and pipeline control outputs of the issue controller
interface issue_ctrl_if;
  import issue_ctrl_pkg::*;
  logic id_valid, id_rs1_r_ena, id_rs2_r_ena, id_rd_w_ena, id_is_bj, id_is_ebreak;
  logic [REG_AW-1:0] id_rs1_r_addr, id_rs2_r_addr, id_rd_w_addr, wb_rd_addr;
  logic ex_bj_done, ex_redirect, mem_busy, wb_w_ena;
  logic issue, if_stall, id_stall, ex_stall, ex_bubble, id_flush, halted;
  logic [CTRL_STATE_W-1:0] ctrl_state;
  modport master (
    output id_valid, id_rs1_r_ena, id_rs1_r_addr, id_rs2_r_ena, id_rs2_r_addr,
           id_rd_w_ena, id_rd_w_addr, id_is_bj, id_is_ebreak,
           ex_bj_done, ex_redirect, mem_busy, wb_w_ena, wb_rd_addr,
    input  issue, if_stall, id_stall, ex_stall, ex_bubble, id_flush, halted, ctrl_state
  );
  modport slave (
    input  id_valid, id_rs1_r_ena, id_rs1_r_addr, id_rs2_r_ena, id_rs2_r_addr,
           id_rd_w_ena, id_rd_w_addr, id_is_bj, id_is_ebreak,
           ex_bj_done, ex_redirect, mem_busy, wb_w_ena, wb_rd_addr,
    output issue, if_stall, id_stall, ex_stall, ex_bubble, id_flush, halted, ctrl_state
  );
endinterface

// File: rtl/issue_ctrl_scoreboard.sv
// issue_scoreboard: per-register pending-write counters with inc/dec and rs1/rs2/rd read ports
module issue_scoreboard
  import issue_ctrl_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inc_ena,
  input  logic [REG_AW-1:0] i_inc_addr,
  input  logic              i_dec_ena,
  input  logic [REG_AW-1:0] i_dec_addr,
  input  logic [REG_AW-1:0] i_rs1_addr,
  input  logic [REG_AW-1:0] i_rs2_addr,
  input  logic [REG_AW-1:0] i_rd_addr,
  output logic [CNT_W-1:0]  o_rs1_cnt,
  output logic [CNT_W-1:0]  o_rs2_cnt,
  output logic [CNT_W-1:0]  o_rd_cnt
);
  logic [CNT_W-1:0] r_cnt [NREG];
  logic [NREG-1:0]  w_inc, w_dec;
  // one-hot decode of the issue and writeback targets, plus the read ports
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_inc[i] = i_inc_ena & (i_inc_addr == REG_AW'(i));
      w_dec[i] = i_dec_ena & (i_dec_addr == REG_AW'(i));
    end
    o_rs1_cnt = r_cnt[i_rs1_addr];
    o_rs2_cnt = r_cnt[i_rs2_addr];
    o_rd_cnt  = r_cnt[i_rd_addr];
  end
  // count up on issue, down on writeback; both on one register cancel, decrement saturates at 0
  always_ff @(posedge clk)
    for (int i = 0; i < NREG; i++)
      if (rst) r_cnt[i] <= '0;
      else if (w_inc[i] & ~w_dec[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
      else if (w_dec[i] & ~w_inc[i] & (r_cnt[i] != '0)) r_cnt[i] <= r_cnt[i] - 1'b1;
  // a writeback with nothing pending means the pipeline lost track of an in-flight write
  always_ff @(posedge clk)
    if (!rst && i_dec_ena && !(i_inc_ena && i_inc_addr == i_dec_addr))
      assert (r_cnt[i_dec_addr] != '0)
      else $error("issue_scoreboard: writeback to x%0d with no pending write", i_dec_addr);
endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: in-order issue/hazard controller with scoreboard and branch/flush/halt sequencing
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int NREG       = 32,
  parameter int CNT_W      = 2,
  parameter int FLUSH_CYC  = 1,
  parameter int WR_THROUGH = 1
) (
  input logic         clk,
  input logic         rst,
  issue_ctrl_if.slave bus
);
  localparam int FW = FLUSH_CYC > 1 ? $clog2(FLUSH_CYC) : 1;
  ctrl_state_e      r_state;
  logic [FW-1:0]    r_fcnt;
  logic [CNT_W-1:0] w_rs1_cnt, w_rs2_cnt, w_rd_cnt;
  logic w_freeze, w_nt, w_eff_run, w_wt1, w_wt2, w_raw, w_waw, w_hold, w_bw_wait;
  logic w_issue, w_inc, w_dec;
  issue_scoreboard #(.NREG(NREG), .CNT_W(CNT_W)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_inc_ena  (w_inc),
    .i_inc_addr (bus.id_rd_w_addr),
    .i_dec_ena  (w_dec),
    .i_dec_addr (bus.wb_rd_addr),
    .i_rs1_addr (bus.id_rs1_r_addr),
    .i_rs2_addr (bus.id_rs2_r_addr),
    .i_rd_addr  (bus.id_rd_w_addr),
    .o_rs1_cnt  (w_rs1_cnt),
    .o_rs2_cnt  (w_rs2_cnt),
    .o_rd_cnt   (w_rd_cnt)
  );
  // hazard detection and stall/bubble/flush decode; a not-taken resolve cycle behaves like RUN
  // so the fall-through instruction already sitting in ID issues without being dropped
  always_comb begin
    w_freeze  = bus.mem_busy & (r_state != CTRL_HALT);
    w_nt      = (r_state == CTRL_BR_WAIT) & bus.ex_bj_done & ~bus.ex_redirect;
    w_eff_run = (r_state == CTRL_RUN) | w_nt;
    w_wt1     = (WR_THROUGH != 0) & bus.wb_w_ena & (bus.wb_rd_addr == bus.id_rs1_r_addr) & (w_rs1_cnt == CNT_W'(1));
    w_wt2     = (WR_THROUGH != 0) & bus.wb_w_ena & (bus.wb_rd_addr == bus.id_rs2_r_addr) & (w_rs2_cnt == CNT_W'(1));
    w_raw     = (bus.id_rs1_r_ena & (bus.id_rs1_r_addr != '0) & (w_rs1_cnt != '0) & ~w_wt1)
              | (bus.id_rs2_r_ena & (bus.id_rs2_r_addr != '0) & (w_rs2_cnt != '0) & ~w_wt2);
    w_waw     = bus.id_rd_w_ena & (bus.id_rd_w_addr != '0) & (w_rd_cnt == '1);
    w_issue   = ~rst & w_eff_run & bus.id_valid & ~w_raw & ~w_waw & ~bus.mem_busy;
    w_hold    = w_eff_run & bus.id_valid & (w_raw | w_waw);
    w_bw_wait = (r_state == CTRL_BR_WAIT) & ~w_nt;
    w_inc     = w_issue & bus.id_rd_w_ena & (bus.id_rd_w_addr != '0);
    w_dec     = ~rst & ~w_freeze & bus.wb_w_ena & (bus.wb_rd_addr != '0);
    bus.issue      = w_issue;
    bus.if_stall   = ~rst & (w_freeze | w_hold | w_bw_wait | (r_state == CTRL_HALT));
    bus.id_stall   = ~rst & (w_freeze | w_hold | w_bw_wait | (r_state == CTRL_HALT));
    bus.ex_stall   = ~rst & w_freeze;
    bus.ex_bubble  = rst | (~w_freeze & ~w_issue);
    bus.id_flush   = rst | (~w_freeze & (r_state == CTRL_FLUSH));
    bus.halted     = ~rst & (r_state == CTRL_HALT);
    bus.ctrl_state = r_state;
  end
  // control FSM; a memory freeze holds state and flush counter, HALT leaves only by reset
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= CTRL_RUN;
      r_fcnt  <= '0;
    end else if (!w_freeze) begin
      if (w_issue && bus.id_is_bj) r_state <= CTRL_BR_WAIT;
      else if (w_issue && bus.id_is_ebreak) r_state <= CTRL_HALT;
      else if (r_state == CTRL_BR_WAIT && bus.ex_bj_done) begin
        r_state <= bus.ex_redirect ? CTRL_FLUSH : CTRL_RUN;
        r_fcnt  <= FW'(FLUSH_CYC - 1);
      end else if (r_state == CTRL_FLUSH) begin
        if (r_fcnt == '0) r_state <= CTRL_RUN;
        else r_fcnt <= r_fcnt - 1'b1;
      end
    end
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed vectors for hazards, saturation, branch/flush, freeze, halt and reset
module tb_issue_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  issue_ctrl_if bus();
  issue_ctrl #(.NREG(32), .CNT_W(2), .FLUSH_CYC(2), .WR_THROUGH(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  task automatic set_id(input logic v, input logic r1e, input logic [4:0] r1, input logic r2e,
                        input logic [4:0] r2, input logic rde, input logic [4:0] rd,
                        input logic bj, input logic eb);
    bus.id_valid = v;
    bus.id_rs1_r_ena = r1e;
    bus.id_rs1_r_addr = r1;
    bus.id_rs2_r_ena = r2e;
    bus.id_rs2_r_addr = r2;
    bus.id_rd_w_ena = rde;
    bus.id_rd_w_addr = rd;
    bus.id_is_bj = bj;
    bus.id_is_ebreak = eb;
  endtask
  task automatic set_wb(input logic e, input logic [4:0] a);
    bus.wb_w_ena = e;
    bus.wb_rd_addr = a;
  endtask
  task automatic set_ex(input logic done, input logic redir, input logic busy);
    bus.ex_bj_done = done;
    bus.ex_redirect = redir;
    bus.mem_busy = busy;
  endtask
  task automatic step(input string tag, input logic iss, input logic ifs, input logic ids,
                      input logic exs, input logic bub, input logic fl, input logic h,
                      input logic [1:0] st);
    logic [8:0] obs, exp;
    #2;
    obs = {bus.issue, bus.if_stall, bus.id_stall, bus.ex_stall, bus.ex_bubble,
           bus.id_flush, bus.halted, bus.ctrl_state};
    exp = {iss, ifs, ids, exs, bub, fl, h, st};
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got iss/ifs/ids/exs/bub/fl/h/st=%b required %b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    set_ex(0, 0, 0);
    @(posedge clk);
    #1;
    step("reset", 0, 0, 0, 0, 1, 1, 0, 0);
    rst = 1'b0;
    set_id(1, 0, 0, 0, 0, 1, 5, 0, 0);
    step("t1_addi", 1, 0, 0, 0, 0, 0, 0, 0);
    set_id(1, 1, 5, 1, 5, 1, 6, 0, 0);
    step("t1_raw", 0, 1, 1, 0, 1, 0, 0, 0);
    set_wb(1, 5);
    step("t1_wr_through", 1, 0, 0, 0, 0, 0, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 6);
    step("t1_wb6", 0, 0, 0, 0, 1, 0, 0, 0);
    set_wb(0, 0);
    set_id(1, 1, 5, 1, 6, 0, 0, 0, 0);
    step("t1_cleared", 1, 0, 0, 0, 0, 0, 0, 0);
    set_id(1, 0, 0, 0, 0, 1, 7, 0, 0);
    step("t2_w1", 1, 0, 0, 0, 0, 0, 0, 0);
    step("t2_w2", 1, 0, 0, 0, 0, 0, 0, 0);
    step("t2_w3", 1, 0, 0, 0, 0, 0, 0, 0);
    step("t2_sat", 0, 1, 1, 0, 1, 0, 0, 0);
    set_wb(1, 7);
    step("t2_wb_same_cycle", 0, 1, 1, 0, 1, 0, 0, 0);
    set_wb(0, 0);
    step("t2_fourth", 1, 0, 0, 0, 0, 0, 0, 0);
    step("t2_back_to_max", 0, 1, 1, 0, 1, 0, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 7);
    for (int i = 0; i < 3; i++) step("t2_drain", 0, 0, 0, 0, 1, 0, 0, 0);
    set_wb(0, 0);
    set_id(1, 1, 7, 0, 0, 0, 0, 0, 0);
    step("t2_empty", 1, 0, 0, 0, 0, 0, 0, 0);
    set_id(1, 0, 0, 0, 0, 0, 0, 1, 0);
    step("t3_beq", 1, 0, 0, 0, 0, 0, 0, 0);
    set_id(1, 1, 3, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("t3_wait", 0, 1, 1, 0, 1, 0, 0, 1);
    set_ex(1, 0, 0);
    step("t3_resolve", 1, 0, 0, 0, 0, 0, 0, 1);
    set_ex(0, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t3_run", 0, 0, 0, 0, 1, 0, 0, 0);
    set_id(1, 0, 0, 0, 0, 0, 0, 1, 0);
    step("t4_jal", 1, 0, 0, 0, 0, 0, 0, 0);
    set_id(1, 1, 3, 0, 0, 0, 0, 0, 0);
    step("t4_wait", 0, 1, 1, 0, 1, 0, 0, 1);
    set_ex(1, 1, 0);
    step("t4_taken", 0, 1, 1, 0, 1, 0, 0, 1);
    set_ex(0, 0, 0);
    step("t4_flush1", 0, 0, 0, 0, 1, 1, 0, 2);
    step("t4_flush2", 0, 0, 0, 0, 1, 1, 0, 2);
    step("t4_run", 1, 0, 0, 0, 0, 0, 0, 0);
    set_id(1, 0, 0, 0, 0, 0, 0, 1, 0);
    step("t5_beq", 1, 0, 0, 0, 0, 0, 0, 0);
    set_id(1, 1, 3, 0, 0, 0, 0, 0, 0);
    set_ex(1, 0, 1);
    for (int i = 0; i < 4; i++) step("t5_frozen", 0, 1, 1, 1, 0, 0, 0, 1);
    set_ex(1, 0, 0);
    step("t5_resolve", 1, 0, 0, 0, 0, 0, 0, 1);
    set_ex(0, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t5_run", 0, 0, 0, 0, 1, 0, 0, 0);
    set_id(1, 0, 0, 0, 0, 1, 9, 0, 0);
    step("t6_wr9", 1, 0, 0, 0, 0, 0, 0, 0);
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
    step("t6_ebreak", 1, 0, 0, 0, 0, 0, 0, 0);
    set_id(1, 1, 9, 0, 0, 0, 0, 0, 0);
    step("t6_halt", 0, 1, 1, 0, 1, 0, 1, 3);
    set_ex(0, 0, 1);
    step("t6_halt_busy", 0, 1, 1, 0, 1, 0, 1, 3);
    set_ex(0, 0, 0);
    rst = 1'b1;
    step("t6_rst", 0, 0, 0, 0, 1, 1, 0, 3);
    rst = 1'b0;
    step("t6_cleared", 1, 0, 0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
